// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-detect scheduler: one pending event per input line,
// shared round-robin onto a single valid/ready event port.
module edge_event_arbiter #(
   parameter int N_CH  = 4,
   parameter int IDX_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   a_i,
   output logic              evt_valid_o,
   input  logic              evt_ready_i,
   output logic [IDX_W-1:0]  evt_ch_o,
   output logic              evt_rise_o,
   output logic [N_CH-1:0]   overflow_o,
   input  logic              clr_ovf_i,
   output logic              dbg_state_o
);

   // Handshake: an event transfers on any posedge where evt_valid_o && evt_ready_i;
   // while valid is high and ready is low, evt_ch_o/evt_rise_o do not change.
   typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

   state_t            state;
   logic [N_CH-1:0]   a_q;
   logic              primed;
   logic [N_CH-1:0]   pend;
   logic [N_CH-1:0]   typ;
   logic [IDX_W-1:0]  rr;

   logic [N_CH-1:0]   edge_v;
   logic              fire;
   logic              gnt_found;
   logic [IDX_W-1:0]  gnt_ch;
   logic [IDX_W-1:0]  cand;
   logic [N_CH-1:0]   gnt_vec;
   logic [N_CH-1:0]   pend_nxt;
   logic [N_CH-1:0]   typ_nxt;
   logic [N_CH-1:0]   ovf_set;

   assign dbg_state_o = state;
   assign edge_v      = primed ? (a_i ^ a_q) : '0;
   assign fire        = ((state == IDLE) || evt_ready_i) && (|pend);
   assign gnt_vec     = fire ? (N_CH'(1) << gnt_ch) : '0;

   // First pending channel at or after the round-robin pointer.
   always_comb begin
      gnt_found = 1'b0;
      gnt_ch    = '0;
      cand      = '0;
      for (int i = 0; i < N_CH; i++) begin
         cand = IDX_W'((int'(rr) + i) % N_CH);
         if (!gnt_found && pend[cand]) begin
            gnt_found = 1'b1;
            gnt_ch    = cand;
         end
      end
   end

   // A new edge on a channel still holding an ungranted event is dropped
   // (oldest kept) and flagged; if the channel is granted now, it reloads.
   always_comb begin
      pend_nxt = pend;
      typ_nxt  = typ;
      ovf_set  = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (edge_v[c]) begin
            if (pend[c] && !gnt_vec[c]) begin
               ovf_set[c] = 1'b1;
            end else begin
               pend_nxt[c] = 1'b1;
               typ_nxt[c]  = a_i[c];
            end
         end else if (gnt_vec[c]) begin
            pend_nxt[c] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         a_q         <= '0;
         primed      <= 1'b0;
         pend        <= '0;
         typ         <= '0;
         rr          <= '0;
         evt_valid_o <= 1'b0;
         evt_ch_o    <= '0;
         evt_rise_o  <= 1'b0;
         overflow_o  <= '0;
      end else begin
         a_q        <= a_i;
         primed     <= 1'b1;
         pend       <= pend_nxt;
         typ        <= typ_nxt;
         overflow_o <= ovf_set | (clr_ovf_i ? '0 : overflow_o);
         if (fire) begin
            evt_valid_o <= 1'b1;
            evt_ch_o    <= gnt_ch;
            evt_rise_o  <= typ[gnt_ch];
            rr          <= (gnt_ch == IDX_W'(N_CH - 1)) ? '0 : gnt_ch + 1'b1;
            state       <= OFFER;
         end else if (state == OFFER && evt_ready_i) begin
            evt_valid_o <= 1'b0;
            state       <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with a small reference model for the
// randomised section; expected events flow through exp_q.
module tb_edge_event_arbiter;
   localparam int N_CH  = 4;
   localparam int IDX_W = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [N_CH-1:0]  a_i;
   logic             evt_valid_o;
   logic             evt_ready_i;
   logic [IDX_W-1:0] evt_ch_o;
   logic             evt_rise_o;
   logic [N_CH-1:0]  overflow_o;
   logic             clr_ovf_i;
   logic             dbg_state_o;

   int total = 0;
   int bad   = 0;
   logic [2:0] exp_q[$];

   // reference model state
   logic            m_primed;
   logic [N_CH-1:0] m_aq, m_pend, m_typ, m_ovf;
   int              m_rr;
   logic            m_valid, m_rise;
   logic [1:0]      m_ch;

   edge_event_arbiter #(.N_CH(N_CH), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset(reset), .a_i(a_i),
      .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
      .evt_ch_o(evt_ch_o), .evt_rise_o(evt_rise_o),
      .overflow_o(overflow_o), .clr_ovf_i(clr_ovf_i),
      .dbg_state_o(dbg_state_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_evt(input string tag, input int ch, input logic rise);
      chk({tag, "_valid"}, 32'(evt_valid_o), 32'd1);
      chk({tag, "_ch"}, 32'(evt_ch_o), 32'(ch));
      chk({tag, "_rise"}, 32'(evt_rise_o), 32'(rise));
   endtask

   task automatic expect_idle(input string tag);
      chk({tag, "_valid"}, 32'(evt_valid_o), 32'd0);
   endtask

   // Advances the model by one posedge using the inputs presented to it.
   task automatic model_step();
      logic [N_CH-1:0] edg, gnt, p;
      logic            fire, found;
      int              g;
      edg   = m_primed ? (a_i ^ m_aq) : '0;
      fire  = (!m_valid || evt_ready_i) && (m_pend != 0);
      gnt   = '0;
      g     = 0;
      found = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (!found && m_pend[(m_rr + i) % N_CH]) begin
            found = 1'b1;
            g     = (m_rr + i) % N_CH;
         end
      end
      if (fire) begin
         gnt[g]  = 1'b1;
         m_ch    = g[1:0];
         m_rise  = m_typ[g];
         m_valid = 1'b1;
         m_rr    = (g + 1) % N_CH;
         exp_q.push_back({m_ch, m_rise});
      end else if (m_valid && evt_ready_i) begin
         m_valid = 1'b0;
      end
      p = m_pend & ~gnt;
      if (clr_ovf_i) m_ovf = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (edg[c]) begin
            if (p[c]) m_ovf[c] = 1'b1;
            else begin
               p[c]     = 1'b1;
               m_typ[c] = a_i[c];
            end
         end
      end
      m_pend   = p;
      m_aq     = a_i;
      m_primed = 1'b1;
   endtask

   initial begin
      logic       hs;
      logic [2:0] hs_val, front;

      // 1: reset values, then hold inputs steady: nothing may be reported
      reset = 1'b0; a_i = 4'b1111; evt_ready_i = 1'b0; clr_ovf_i = 1'b0;
      repeat (2) tick();
      chk("rst_valid", 32'(evt_valid_o), 32'd0);
      chk("rst_ch", 32'(evt_ch_o), 32'd0);
      chk("rst_rise", 32'(evt_rise_o), 32'd0);
      chk("rst_ovf", 32'(overflow_o), 32'd0);
      chk("rst_state", 32'(dbg_state_o), 32'd0);
      reset = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         expect_idle("prime_quiet");
      end

      // warm-up fall on ch2 with ready high
      a_i = 4'b1011; evt_ready_i = 1'b1;
      tick(); expect_idle("w_edge");
      tick(); expect_evt("w_ch2f", 2, 1'b0);
      tick(); expect_idle("w_done");

      // 2: ch2 rise, ready low for three offered cycles
      evt_ready_i = 1'b0; a_i = 4'b1111;
      tick(); expect_idle("t2_edge");
      tick(); expect_evt("t2_off1", 2, 1'b1);
      tick(); expect_evt("t2_off2", 2, 1'b1);
      tick(); expect_evt("t2_off3", 2, 1'b1);
      evt_ready_i = 1'b1;
      tick(); expect_idle("t2_acc");

      // 3a: simultaneous falls with pointer at 3 -> wrap order 3,0,1
      a_i = 4'b0100;
      tick(); expect_idle("t3a_edge");
      tick(); expect_evt("t3a_e0", 3, 1'b0);
      tick(); expect_evt("t3a_e1", 0, 1'b0);
      tick(); expect_evt("t3a_e2", 1, 1'b0);
      tick(); expect_idle("t3a_done");
      // 3b/3c: bring pointer to 0 via ch3
      a_i = 4'b1100;
      tick(); tick(); expect_evt("t3b", 3, 1'b1);
      tick(); expect_idle("t3b_done");
      a_i = 4'b0100;
      tick(); tick(); expect_evt("t3c", 3, 1'b0);
      tick(); expect_idle("t3c_done");
      // 3d: ch0,ch1,ch3 rise together, pointer 0
      a_i = 4'b1111;
      tick(); expect_idle("t3d_edge");
      tick(); expect_evt("t3d_e0", 0, 1'b1);
      tick(); expect_evt("t3d_e1", 1, 1'b1);
      tick(); expect_evt("t3d_e2", 3, 1'b1);
      tick(); expect_idle("t3d_done");
      // 3e: single ch0 event after wrap
      a_i = 4'b1110;
      tick(); tick(); expect_evt("t3e", 0, 1'b0);
      tick(); expect_idle("t3e_done");

      // 4: collision on ch1 with ready low
      a_i = 4'b1100;
      tick(); tick(); expect_evt("t4_prep", 1, 1'b0);
      tick(); expect_idle("t4_prep_done");
      evt_ready_i = 1'b0;
      a_i = 4'b1110;
      tick(); expect_idle("t4_k0"); chk("t4_k0_ovf", 32'(overflow_o), 32'd0);
      a_i = 4'b1100;
      tick(); expect_evt("t4_k1", 1, 1'b1); chk("t4_k1_ovf", 32'(overflow_o), 32'd0);
      a_i = 4'b1110; clr_ovf_i = 1'b1;
      tick(); expect_evt("t4_k2", 1, 1'b1); chk("t4_set_over_clr", 32'(overflow_o), 32'b0010);
      tick(); expect_evt("t4_k3", 1, 1'b1); chk("t4_clr", 32'(overflow_o), 32'd0);
      clr_ovf_i = 1'b0; evt_ready_i = 1'b1;
      tick(); expect_evt("t4_kept_fall", 1, 1'b0);
      tick(); expect_idle("t4_done");

      // 5: reset while offering with two events pending
      evt_ready_i = 1'b0; a_i = 4'b0000;
      tick(); expect_idle("t5_edge");
      tick(); expect_evt("t5_off", 2, 1'b0);
      #1 reset = 1'b0;
      #1;
      chk("t5_async_valid", 32'(evt_valid_o), 32'd0);
      chk("t5_async_ch", 32'(evt_ch_o), 32'd0);
      a_i = 4'b1010;
      tick(); tick();
      chk("t5_rst_state", 32'(dbg_state_o), 32'd0);
      reset = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         evt_ready_i = (i % 2 == 0);
         tick();
         expect_idle("t5_no_stale");
      end

      // 6: random lines and ready against the model
      m_primed = 1'b1; m_aq = 4'b1010; m_pend = '0; m_typ = '0; m_ovf = '0;
      m_rr = 0; m_valid = 1'b0; m_ch = '0; m_rise = 1'b0;
      for (int cyc = 0; cyc < 44; cyc++) begin
         if (cyc < 32) begin
            for (int c = 0; c < N_CH; c++) a_i[c] = 1'($urandom_range(0, 1));
            evt_ready_i = 1'($urandom_range(0, 1));
            clr_ovf_i   = ($urandom_range(0, 7) == 0);
         end else begin
            evt_ready_i = 1'b1;
            clr_ovf_i   = 1'b0;
         end
         hs     = evt_valid_o && evt_ready_i;
         hs_val = {evt_ch_o, evt_rise_o};
         model_step();
         tick();
         if (hs) begin
            if (exp_q.size() == 0) begin
               chk("sb_underflow", 32'(hs_val), 32'h8);
            end else begin
               front = exp_q.pop_front();
               chk("sb_event", 32'(hs_val), 32'(front));
            end
         end
         chk("rnd_valid", 32'(evt_valid_o), 32'(m_valid));
         chk("rnd_ovf", 32'(overflow_o), 32'(m_ovf));
         if (m_valid) chk("rnd_offer", 32'({evt_ch_o, evt_rise_o}), 32'({m_ch, m_rise}));
      end
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
